// File: rtl/io_peripheral_bank_if.sv
// I/O window bus between the processor and the peripheral bank.
//   addr     processor data address (only [2:0] decoded by the bank)
//   wr_data  processor store data
//   io_we    I/O write strobe, already qualified to the I/O window
//   rd_data  registered read data returned to the load-data mux
interface io_peripheral_bank_if;
    logic [15:0] addr;
    logic [15:0] wr_data;
    logic        io_we;
    logic [15:0] rd_data;

    modport master (output addr, output wr_data, output io_we, input rd_data);
    modport slave  (input addr, input wr_data, input io_we, output rd_data);
endinterface

// File: rtl/io_peripheral_bank.sv
// io_peripheral_bank: memory-mapped I/O responder.
//   Register map (addr[2:0], upper address bits alias):
//     0 LED (RW)  1 SW (RO)  2 BTN_EVT (R/W1C)  3 TCNT (RW)
//     4 TCTRL (RW: EN, AUTO, EXP W1C, IE)  5 TRELOAD (RW)  6,7 read 0
// Ports:
//   clk, reset  clock and asynchronous active-high reset
//   bus         slave side of the I/O bus (addr, wr_data, io_we, rd_data)
//   switches    raw switch levels (synchronized internally)
//   buttons     raw button levels, active-high (synchronized internally)
//   leds        LED register contents
//   irq         timer interrupt request (EXP & IE, from flops only)

// One button lane: two-flop synchronizer, history flop and sticky event bit.
module io_btn_lane (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic clr,      // W1C of this bit this cycle
    output logic evt
);
    logic s1, s2, hist;
    logic rise;

    assign rise = s2 & ~hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            hist <= 1'b0;
            evt  <= 1'b0;
        end else begin
            s1   <= btn_raw;
            s2   <= s1;
            hist <= s2;
            // a new edge beats a simultaneous clear
            evt  <= rise | (evt & ~clr);
        end
    end
endmodule

module io_peripheral_bank #(
    parameter int LED_W    = 10,
    parameter int SW_W     = 10,
    parameter int BTN_W    = 4,
    parameter int PRESCALE = 50000
) (
    input  logic                 clk,
    input  logic                 reset,
    io_peripheral_bank_if.slave  bus,
    input  logic [SW_W-1:0]      switches,
    input  logic [BTN_W-1:0]     buttons,
    output logic [LED_W-1:0]     leds,
    output logic                 irq
);
    localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    localparam logic [2:0] A_LED   = 3'd0;
    localparam logic [2:0] A_SW    = 3'd1;
    localparam logic [2:0] A_BTN   = 3'd2;
    localparam logic [2:0] A_TCNT  = 3'd3;
    localparam logic [2:0] A_TCTRL = 3'd4;
    localparam logic [2:0] A_TRLD  = 3'd5;

    logic [2:0] sel;
    logic       unused_addr;

    assign sel         = bus.addr[2:0];
    assign unused_addr = ^bus.addr[15:3];

    logic wr_led, wr_btn, wr_tcnt, wr_tctrl, wr_trld;
    assign wr_led   = bus.io_we && (sel == A_LED);
    assign wr_btn   = bus.io_we && (sel == A_BTN);
    assign wr_tcnt  = bus.io_we && (sel == A_TCNT);
    assign wr_tctrl = bus.io_we && (sel == A_TCTRL);
    assign wr_trld  = bus.io_we && (sel == A_TRLD);

    // ---------------- LED register ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       leds <= '0;
        else if (wr_led) leds <= bus.wr_data[LED_W-1:0];
    end

    // ---------------- switch synchronizer ----------------
    logic [SW_W-1:0] sw_s1, sw_s2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= switches;
            sw_s2 <= sw_s1;
        end
    end

    // ---------------- button lanes ----------------
    logic [BTN_W-1:0] btn_evt;

    for (genvar i = 0; i < BTN_W; i++) begin : g_btn
        io_btn_lane u_lane (
            .clk     (clk),
            .reset   (reset),
            .btn_raw (buttons[i]),
            .clr     (wr_btn & bus.wr_data[i]),
            .evt     (btn_evt[i])
        );
    end

    // ---------------- timer ----------------
    logic [PW-1:0] presc;
    logic [15:0]   tcnt, tcnt_nx;
    logic [15:0]   treload;
    logic          en, en_nx;
    logic          auto_rl, auto_nx;
    logic          expd, exp_nx;
    logic          ie, ie_nx;
    logic          tick;

    assign tick = en && (presc == PMAX);

    // Prescaler restarts from 0 whenever the timer is stopped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         presc <= '0;
        else if (!en)      presc <= '0;
        else if (tick)     presc <= '0;
        else               presc <= presc + PW'(1);
    end

    // Tick update first, then CPU writes override it; the only exception
    // is EXP, where the tick's set wins over a same-cycle W1C.
    always_comb begin
        logic exp_set;
        tcnt_nx = tcnt;
        en_nx   = en;
        auto_nx = auto_rl;
        ie_nx   = ie;
        exp_set = 1'b0;

        if (tick) begin
            if (tcnt != 16'd0) begin
                tcnt_nx = tcnt - 16'd1;
            end else begin
                exp_set = 1'b1;
                if (auto_rl) tcnt_nx = treload;
                else         en_nx   = 1'b0;
            end
        end

        if (wr_tcnt) tcnt_nx = bus.wr_data;
        if (wr_tctrl) begin
            en_nx   = bus.wr_data[0];
            auto_nx = bus.wr_data[1];
            ie_nx   = bus.wr_data[3];
        end

        exp_nx = exp_set | (expd & ~(wr_tctrl & bus.wr_data[2]));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt    <= '0;
            treload <= '0;
            en      <= 1'b0;
            auto_rl <= 1'b0;
            expd    <= 1'b0;
            ie      <= 1'b0;
        end else begin
            tcnt    <= tcnt_nx;
            en      <= en_nx;
            auto_rl <= auto_nx;
            expd    <= exp_nx;
            ie      <= ie_nx;
            if (wr_trld) treload <= bus.wr_data;
        end
    end

    assign irq = expd & ie;

    // ---------------- read path ----------------
    // Selected from current register values, so a read in the same cycle
    // as a write returns the pre-write contents.
    logic [15:0] rd_nx;

    always_comb begin
        rd_nx = '0;
        case (sel)
            A_LED:   rd_nx[LED_W-1:0] = leds;
            A_SW:    rd_nx[SW_W-1:0]  = sw_s2;
            A_BTN:   rd_nx[BTN_W-1:0] = btn_evt;
            A_TCNT:  rd_nx            = tcnt;
            A_TCTRL: rd_nx[3:0]       = {ie, expd, auto_rl, en};
            A_TRLD:  rd_nx            = treload;
            default: rd_nx            = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) bus.rd_data <= '0;
        else       bus.rd_data <= rd_nx;
    end
endmodule

// File: tb/tb_io_peripheral_bank.sv
module tb_io_peripheral_bank;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] sw = '0;
    logic [3:0] btn = '0;
    logic [9:0] leds;
    logic       irq;

    io_peripheral_bank_if bif ();

    io_peripheral_bank #(.LED_W(10), .SW_W(10), .BTN_W(4), .PRESCALE(P)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bif),
        .switches (sw),
        .buttons  (btn),
        .leds     (leds),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model (register-level view) ----------------
    logic [9:0]  m_led, m_sw1, m_sw2;
    logic [3:0]  m_evt, m_b1, m_b2, m_bh;
    logic [15:0] m_tcnt, m_reload, m_rd;
    logic        m_en, m_auto, m_exp, m_ie;
    int          m_pc;

    task automatic m_reset();
        m_led = '0; m_sw1 = '0; m_sw2 = '0;
        m_evt = '0; m_b1 = '0; m_b2 = '0; m_bh = '0;
        m_tcnt = '0; m_reload = '0; m_rd = '0;
        m_en = 0; m_auto = 0; m_exp = 0; m_ie = 0; m_pc = 0;
    endtask

    function automatic logic [15:0] m_read(input logic [2:0] a);
        case (a)
            3'd0: return {6'b0, m_led};
            3'd1: return {6'b0, m_sw2};
            3'd2: return {12'b0, m_evt};
            3'd3: return m_tcnt;
            3'd4: return {12'b0, m_ie, m_exp, m_auto, m_en};
            3'd5: return m_reload;
            default: return 16'h0;
        endcase
    endfunction

    // One clock: capture inputs, advance the model, compare outputs.
    task automatic step();
        logic [15:0] a, w;
        logic        we, tick, exp_tick, nen, nauto, nie, nexp;
        logic [15:0] ncnt;
        logic [9:0]  s;
        logic [3:0]  b, clr;
        a = bif.addr; w = bif.wr_data; we = bif.io_we; s = sw; b = btn;
        @(posedge clk);
        m_rd = m_read(a[2:0]);
        tick = m_en && (m_pc == P - 1);
        exp_tick = 0; ncnt = m_tcnt; nen = m_en;
        nauto = m_auto; nie = m_ie; nexp = m_exp;
        if (tick) begin
            if (m_tcnt != 0) ncnt = m_tcnt - 1;
            else begin
                exp_tick = 1;
                if (m_auto) ncnt = m_reload;
                else nen = 0;
            end
        end
        m_pc = m_en ? (m_pc + 1) % P : 0;
        clr = (we && a[2:0] == 3'd2) ? w[3:0] : 4'h0;
        m_evt = (m_evt & ~clr) | (m_b2 & ~m_bh);
        m_bh = m_b2; m_b2 = m_b1; m_b1 = b;
        m_sw2 = m_sw1; m_sw1 = s;
        if (we) begin
            case (a[2:0])
                3'd0: m_led = w[9:0];
                3'd3: ncnt = w;
                3'd4: begin nen = w[0]; nauto = w[1]; nie = w[3]; if (w[2]) nexp = 0; end
                3'd5: m_reload = w;
                default: ;
            endcase
        end
        if (exp_tick) nexp = 1;
        m_tcnt = ncnt; m_en = nen; m_auto = nauto; m_ie = nie; m_exp = nexp;
        #1;
        chk("m_rd", bif.rd_data, m_rd);
        chk("m_leds", leds, m_led);
        chk("m_irq", irq, m_exp & m_ie);
    endtask

    task automatic idle(input int n);
        bif.io_we = 0;
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bif.addr = a; bif.wr_data = d; bif.io_we = 1;
        step();
        bif.io_we = 0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        bif.addr = a; bif.io_we = 0;
        step();
        d = bif.rd_data;
    endtask

    logic [15:0] v;
    int          k;

    initial begin
        bif.addr = 16'hC000; bif.wr_data = '0; bif.io_we = 0;
        m_reset();
        #22 reset = 0;
        #1;
        chk("rst_rd", bif.rd_data, 16'h0);
        chk("rst_leds", leds, 10'h0);
        chk("rst_irq", irq, 1'b0);

        // LED write / read, unmapped read
        wr(16'hC000, 16'h03FF);
        chk("led_out", leds, 10'h3FF);
        rd(16'hC000, v); chk("led_rd", v, 16'h03FF);
        rd(16'hC006, v); chk("rd_6", v, 16'h0000);
        rd(16'hFFF8, v); chk("led_alias", v, 16'h03FF);

        // switches
        sw = 10'h2A5;
        idle(2);
        rd(16'hC001, v); chk("sw_rd", v, 16'h02A5);

        // button pulse, W1C, then edge colliding with W1C
        btn = 4'b0010; step(); btn = 4'b0000;
        idle(3);
        rd(16'hC002, v); chk("btn_evt", v, 16'h0002);
        wr(16'hC002, 16'h0002);
        rd(16'hC002, v); chk("btn_w1c", v, 16'h0000);
        btn = 4'b0010; step(); step();
        wr(16'hC002, 16'h0002);       // rise lands in this same cycle
        rd(16'hC002, v); chk("btn_set_wins", v, 16'h0002);
        btn = 4'b0000; idle(3);
        wr(16'hC002, 16'h000F);

        // auto-reload timer
        wr(16'hC005, 16'd2);
        wr(16'hC003, 16'd2);
        wr(16'hC004, 16'h000B);
        k = 0;
        while (!irq && k < 40) begin step(); k++; end
        chk("irq_lat", k, 12);
        rd(16'hC003, v); chk("tcnt_reload", v, 16'd2);
        wr(16'hC004, 16'h000F);       // W1C EXP, keep EN/AUTO/IE
        chk("irq_clr", irq, 1'b0);
        k = 2;
        while (!irq && k < 40) begin step(); k++; end
        chk("irq_period", k, 12);
        wr(16'hC004, 16'h0004);       // stop and clear
        chk("irq_off", irq, 1'b0);

        // one-shot timer
        wr(16'hC003, 16'd1);
        wr(16'hC004, 16'h0001);
        idle(8);
        rd(16'hC004, v); chk("oneshot_ctrl", v, 16'h0004);
        rd(16'hC003, v); chk("oneshot_tcnt", v, 16'h0000);
        idle(20);
        rd(16'hC003, v); chk("oneshot_hold", v, 16'h0000);

        // CPU write beats tick
        wr(16'hC003, 16'h0100);
        wr(16'hC004, 16'h0005);       // EN, clear EXP
        idle(3);
        wr(16'hC003, 16'h1234);       // tick happens in this cycle
        rd(16'hC003, v); chk("wr_beats_tick", v, 16'h1234);

        // asynchronous reset mid-count
        idle(5);
        #2 reset = 1;
        #1;
        chk("arst_leds", leds, 10'h0);
        chk("arst_rd", bif.rd_data, 16'h0);
        chk("arst_irq", irq, 1'b0);
        m_reset();
        sw = '0;
        #2 reset = 0;
        idle(30);
        rd(16'hC003, v); chk("arst_tcnt", v, 16'h0000);
        rd(16'hC004, v); chk("arst_tctrl", v, 16'h0000);

        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            bif.addr    = {2'b11, 11'($urandom), 3'($urandom)};
            bif.wr_data = 16'($urandom);
            if (bif.addr[2:0] == 3'd3 || bif.addr[2:0] == 3'd5)
                bif.wr_data = 16'($urandom_range(0, 12));
            bif.io_we   = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) btn = 4'($urandom);
            if ($urandom_range(0, 15) == 0) sw = 10'($urandom);
            step();
        end
        bif.io_we = 0;

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
